// File: rtl/key_sched_ctrl.sv
// ----------------------------------------------------------------------------
// key_sched_ctrl
//
// Iterative AES-128 round-key scheduler controller. A cipher key is accepted
// over a valid/ready handshake, then an external one-round key-expansion step
// datapath is driven ten times with the matching rcon. Every round key
// rk[0..10] is kept in a local register file and served through a registered,
// indexed read port.
//
// Ports
//   clk, rst_n      clock / asynchronous active-low reset
//   key_valid       in   new cipher key offered (accepted only in IDLE)
//   key_ready       out  controller idle and able to take a key
//   key_in[127:0]   in   cipher key, word 0 in [127:96]
//   abort           in   synchronous abort; returns to IDLE and zeroizes
//   busy            out  expansion in progress
//   keys_ready      out  all 11 round keys valid
//   step_key_in     out  previous round key to the step datapath
//   step_rcon       out  rcon for the round being computed
//   step_key_out    in   next round key from the step datapath
//   rd_idx[3:0]     in   round-key index to read
//   rd_key[127:0]   out  registered round key (0 for index 11..15)
//   rd_valid        out  rd_key holds a valid round key
//
// STEP_LAT: cycles from step inputs presented to step_key_out valid (1..4).
// ----------------------------------------------------------------------------

// One round-key storage slot. Clear wins over write so abort always zeroizes.
module key_sched_rk_slot (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_we,
    input  logic [127:0] i_d,
    output logic [127:0] o_q
);
    logic [127:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_q <= '0;
        else if (i_clr)  r_q <= '0;
        else if (i_we)   r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

module key_sched_ctrl #(
    parameter int STEP_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         abort,
    output logic         busy,
    output logic         keys_ready,
    output logic [127:0] step_key_in,
    output logic [7:0]   step_rcon,
    input  logic [127:0] step_key_out,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         rd_valid
);
    localparam int         NUM_RK     = 11;
    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [2:0] LAT_INIT   = 3'(STEP_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic [2:0]   r_lat;
    logic         r_keys_ready;
    logic [127:0] r_rd_key;
    logic         r_rd_valid;

    logic         w_accept;
    logic         w_capture;
    logic         w_last;
    logic         w_busy;
    logic [3:0]   w_prev_idx;
    logic         w_rd_in_range;
    logic [NUM_RK-1:0][127:0] w_rk;

    // GF(2^8) multiply-by-x, used to walk the rcon sequence.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    assign w_last = (r_round == LAST_ROUND);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (key_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // Step result is valid on the edge where the counter is 1.
                if (r_lat == 3'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_last ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Abort overrides everything, including a key offered this cycle.
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_accept    = 1'b0;
            w_capture   = 1'b0;
        end
    end

    assign key_ready = (r_state == S_IDLE);
    assign w_busy    = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign busy      = w_busy;

    // ------------------------------------------------------------------
    // Round / rcon / latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round <= 4'd1;
            r_rcon  <= 8'h00;
            r_lat   <= 3'd0;
        end else if (abort) begin
            r_round <= 4'd1;
            r_rcon  <= 8'h00;
            r_lat   <= 3'd0;
        end else if (w_accept) begin
            r_round <= 4'd1;
            r_rcon  <= 8'h01;
        end else if (r_state == S_ISSUE) begin
            r_lat <= LAT_INIT;
        end else if (r_state == S_WAIT) begin
            r_lat <= r_lat - 3'd1;
            // round/rcon stay put on the last capture so step outputs are
            // stable right up to the final edge; they are gated off in IDLE.
            if (w_capture && !w_last) begin
                r_round <= r_round + 4'd1;
                r_rcon  <= xtime(r_rcon);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_keys_ready <= 1'b0;
        else if (abort || w_accept)    r_keys_ready <= 1'b0;
        else if (w_capture && w_last)  r_keys_ready <= 1'b1;
    end

    assign keys_ready = r_keys_ready;

    // ------------------------------------------------------------------
    // Round-key register file: slot 0 takes the cipher key, slot n takes
    // the step result when round n is captured.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RK; gi++) begin : g_rk
        localparam logic [3:0] IDX = 4'(gi);
        logic         w_we;
        logic [127:0] w_d;

        if (gi == 0) begin : g_key
            assign w_we = w_accept;
            assign w_d  = key_in;
        end else begin : g_step
            assign w_we = w_capture && (r_round == IDX);
            assign w_d  = step_key_out;
        end

        key_sched_rk_slot u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .i_clr (abort),
            .i_we  (w_we),
            .i_d   (w_d),
            .o_q   (w_rk[gi])
        );
    end

    // ------------------------------------------------------------------
    // Step datapath drive, zero while idle.
    // ------------------------------------------------------------------
    assign w_prev_idx  = r_round - 4'd1;
    assign step_key_in = w_busy ? w_rk[w_prev_idx] : '0;
    assign step_rcon   = w_busy ? r_rcon : 8'h00;

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    assign w_rd_in_range = (rd_idx <= LAST_ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_key   <= '0;
            r_rd_valid <= 1'b0;
        end else if (abort) begin
            // Zeroize the output register too, not just the key file.
            r_rd_key   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_key   <= w_rd_in_range ? w_rk[rd_idx] : '0;
            r_rd_valid <= r_keys_ready && w_rd_in_range;
        end
    end

    assign rd_key   = r_rd_key;
    assign rd_valid = r_rd_valid;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: two instances (STEP_LAT=1 and 3), each with a
// behavioural step datapath of matching latency. Expected keys come from a
// FIPS-197 word-level expansion computed in the bench.
module tb_key_sched_ctrl;
    logic         clk;
    logic         rst_n;
    logic         kv    [2];
    logic [127:0] kin   [2];
    logic         ab    [2];
    logic [3:0]   ridx  [2];
    logic         krdy  [2];
    logic         bsy   [2];
    logic         kr    [2];
    logic [127:0] ski   [2];
    logic [7:0]   src   [2];
    logic [127:0] sko   [2];
    logic [127:0] rk    [2];
    logic         rv    [2];

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [11];
    logic [7:0]   rq [$];
    logic [7:0]   rc_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- GF / S-box model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input int x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // One expansion round, as the external step datapath would compute it.
    function automatic logic [127:0] step_fn(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = subword({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Full FIPS-197 expansion over 44 words.
    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- DUTs + step models ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [127:0] pipe [L];

        key_sched_ctrl #(.STEP_LAT(L)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .key_valid    (kv[g]),
            .key_ready    (krdy[g]),
            .key_in       (kin[g]),
            .abort        (ab[g]),
            .busy         (bsy[g]),
            .keys_ready   (kr[g]),
            .step_key_in  (ski[g]),
            .step_rcon    (src[g]),
            .step_key_out (sko[g]),
            .rd_idx       (ridx[g]),
            .rd_key       (rk[g]),
            .rd_valid     (rv[g])
        );

        always @(posedge clk) begin
            pipe[0] <= step_fn(ski[g], src[g]);
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign sko[g] = pipe[L-1];
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rkey();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk_reset_vals(input int d, input string tag);
        chk({tag, "_key_ready"},  krdy[d], 1);
        chk({tag, "_busy"},       bsy[d],  0);
        chk({tag, "_keys_ready"}, kr[d],   0);
        chk({tag, "_rd_valid"},   rv[d],   0);
        chk({tag, "_rd_key"},     rk[d],   0);
        chk({tag, "_step_key"},   ski[d],  0);
        chk({tag, "_step_rcon"},  src[d],  0);
    endtask

    // Accept a key at the next edge; leaves the bench just after the accept edge.
    task automatic start(input int d, input logic [127:0] key);
        ref_expand(key);
        rq.delete();
        @(negedge clk);
        ridx[d] = 4'd0;
        chk("key_ready_idle", krdy[d], 1);
        kv[d] = 1'b1; kin[d] = key;
        @(posedge clk); #1;
        kv[d] = 1'b0;
        chk("keys_ready_drop", kr[d], 0);
        chk("busy_after_accept", bsy[d], 1);
        chk("key_ready_busy", krdy[d], 0);
    endtask

    // Wait for keys_ready, watching step outputs; checks latency and rcon walk.
    task automatic wait_done(input int d);
        int cyc, bad_busy, bad_kr, bad_ski;
        cyc = 0; bad_busy = 0; bad_kr = 0; bad_ski = 0;
        while (!kr[d] && cyc < 400) begin
            if (!bsy[d] || krdy[d]) bad_busy++;
            if (rq.size() == 0 || rq[$] !== src[d]) rq.push_back(src[d]);
            if (rq.size() <= 10 && ski[d] !== exp_rk[rq.size()-1]) bad_ski++;
            @(posedge clk); #1; cyc++;
        end
        kv[d] = 1'b0;
        chk("done_cycles", 128'(cyc), 128'(10 * (lat_of(d) + 1)));
        chk("busy_during", 128'(bad_busy), 0);
        chk("step_key_in", 128'(bad_ski), 0);
        chk("rcon_count", 128'(rq.size()), 10);
        for (int i = 0; i < 10 && i < rq.size(); i++)
            chk($sformatf("rcon[%0d]", i), rq[i], rc_exp[i]);
        chk("key_ready_at_done", krdy[d], 1);
        chk("busy_at_done", bsy[d], 0);
        chk("step_rcon_idle", src[d], 0);
        chk("rd_valid_lag", rv[d], 0);
        @(posedge clk); #1;
        chk("rd_valid_rise", rv[d], 1);
        chk("keys_ready_hold", kr[d], 1);
    endtask

    task automatic rd_chk(input int d, input int idx, input bit valid);
        @(negedge clk);
        ridx[d] = 4'(idx);
        @(posedge clk); #1;
        chk($sformatf("rd_key[%0d]", idx), rk[d], (valid && idx <= 10) ? exp_rk[idx] : 128'h0);
        chk($sformatf("rd_valid[%0d]", idx), rv[d], (idx <= 10) ? valid : 1'b0);
    endtask

    task automatic sweep(input int d, input bit valid);
        for (int i = 0; i < 16; i++) rd_chk(d, i, valid);
    endtask

    // ---------------- main ----------------
    initial begin
        for (int x = 0; x < 256; x++) sb[x] = sbox_calc(x);
        for (int d = 0; d < 2; d++) begin
            kv[d] = 0; kin[d] = '0; ab[d] = 0; ridx[d] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals(0, "rst0");
        chk_reset_vals(1, "rst1");
        @(negedge clk) rst_n = 1'b1;

        // FIPS-197 key, STEP_LAT=1
        start(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done(0);
        @(negedge clk) ridx[0] = 4'd1;
        @(posedge clk); #1;
        chk("fips_rk1", rk[0], 128'ha0fafe1788542cb123a339392a6c7605);
        @(negedge clk) ridx[0] = 4'd10;
        @(posedge clk); #1;
        chk("fips_rk10", rk[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweep(0, 1);

        // Same key, STEP_LAT=3
        start(1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_done(1);
        sweep(1, 1);

        // Second key held on key_valid during expansion is ignored
        begin
            logic [127:0] ka, kb;
            ka = rkey(); kb = rkey();
            start(0, ka);
            kv[0] = 1'b1; kin[0] = kb;
            wait_done(0);
            sweep(0, 1);
            start(0, kb);
            wait_done(0);
            sweep(0, 1);
        end

        // Abort at round 5, with a key offered in the same cycle
        begin
            int n;
            start(0, rkey());
            n = 0;
            while (src[0] !== 8'h10 && n < 200) begin @(posedge clk); #1; n++; end
            chk("abort_reach_r5", 128'(n < 200), 1);
            @(negedge clk);
            ab[0] = 1'b1; kv[0] = 1'b1; kin[0] = rkey();
            @(posedge clk); #1;
            ab[0] = 1'b0; kv[0] = 1'b0;
            chk("abort_busy", bsy[0], 0);
            chk("abort_key_ready", krdy[0], 1);
            chk("abort_keys_ready", kr[0], 0);
            chk("abort_rd_valid", rv[0], 0);
            chk("abort_rd_key", rk[0], 0);
            chk("abort_step_rcon", src[0], 0);
            sweep(0, 0);
            start(0, rkey());
            wait_done(0);
            sweep(0, 1);
        end

        // Reset pulsed mid-WAIT on the STEP_LAT=3 instance
        start(1, rkey());
        repeat (13) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk_reset_vals(1, "midrst");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_ready", kr[1], 0);
        chk("midrst_idle", krdy[1], 1);
        start(1, rkey());
        wait_done(1);
        for (int i = 0; i < 24; i++) rd_chk(1, int'($urandom_range(15, 0)), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
